// File: rtl/reg_wb_queue.sv
// Writeback queue between execute and the register file: a small in-order FIFO
// that drains one entry per cycle and forwards its pending values to the read stage.
module reg_wb_queue #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               in_rd,
   input  logic [XLEN-1:0]          in_data,
   output logic                     wr_en,
   output logic [4:0]               wr_addr,
   output logic [XLEN-1:0]          wr_data,
   input  logic [4:0]               q_a1,
   input  logic [4:0]               q_a2,
   output logic                     hit1,
   output logic                     hit2,
   output logic [XLEN-1:0]          fwd1,
   output logic [XLEN-1:0]          fwd2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [4:0]      rd_mem_q   [DEPTH];
   logic [XLEN-1:0] data_mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic [PW-1:0]   idx;

   always_comb begin
      in_ready = (count_q != CW'(DEPTH));
      pop      = (count_q != '0);
      // x0 writes are accepted but never stored
      push     = in_valid && in_ready && (in_rd != 5'd0);

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      if (push) begin
         tail_d = tail_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is not reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[tail_q]   <= in_rd;
         data_mem_q[tail_q] <= in_data;
      end
   end

   always_comb begin
      wr_en   = pop;
      wr_addr = pop ? rd_mem_q[head_q]   : 5'd0;
      wr_data = pop ? data_mem_q[head_q] : '0;
      count   = count_q;
   end

   // Walk oldest to youngest so the last match seen wins.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      fwd1 = '0;
      fwd2 = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (CW'(i) < count_q) begin
            if ((q_a1 != 5'd0) && (rd_mem_q[idx] == q_a1)) begin
               hit1 = 1'b1;
               fwd1 = data_mem_q[idx];
            end
            if ((q_a2 != 5'd0) && (rd_mem_q[idx] == q_a2)) begin
               hit2 = 1'b1;
               fwd2 = data_mem_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: a transaction model tracks pending entries and is compared
// every cycle against the write and bypass ports, alongside directed scenario checks.
module tb_reg_wb_queue;

   localparam int XLEN  = 64;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } ent_t;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_rd;
   logic [XLEN-1:0] in_data;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [4:0]      q_a1;
   logic [4:0]      q_a2;
   logic            hit1;
   logic            hit2;
   logic [XLEN-1:0] fwd1;
   logic [XLEN-1:0] fwd2;
   logic [2:0]      count;

   ent_t       mq[$];
   logic [4:0] wlog[$];
   int         checks   = 0;
   int         failures = 0;
   bit         mon_en   = 0;

   reg_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .q_a1(q_a1), .q_a2(q_a2), .hit1(hit1), .hit2(hit2),
      .fwd1(fwd1), .fwd2(fwd2), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference queue: accept against pre-edge occupancy, pop the head every busy edge.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
         end else if (in_valid && (in_rd != 5'd0) && (mq.size() != DEPTH)) begin
            mq.push_back({in_rd, in_data});
            if (mq.size() > 1) void'(mq.pop_front());
         end else if (mq.size() != 0) begin
            void'(mq.pop_front());
         end
      end
   end

   function automatic void lookup(input logic [4:0] a, output logic h, output logic [XLEN-1:0] f);
      h = 1'b0;
      f = '0;
      foreach (mq[i]) begin
         if ((a != 5'd0) && (mq[i].rd == a)) begin
            h = 1'b1;
            f = mq[i].data;
         end
      end
   endfunction

   // Scoreboard comparison on the falling edge, away from the update edge.
   initial begin
      logic            e_en, e_h1, e_h2;
      logic [4:0]      e_addr;
      logic [XLEN-1:0] e_data, e_f1, e_f2;
      logic [2:0]      e_cnt;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            e_en   = (mq.size() != 0);
            e_addr = e_en ? mq[0].rd : 5'd0;
            e_data = e_en ? mq[0].data : '0;
            e_cnt  = 3'(mq.size());
            lookup(q_a1, e_h1, e_f1);
            lookup(q_a2, e_h2, e_f2);
            checks += 6;
            if (count !== e_cnt) begin
               failures++;
               $display("FAIL mon_count t=%0t got=%0d exp=%0d", $time, count, e_cnt);
            end
            if (in_ready !== (e_cnt != 3'(DEPTH))) begin
               failures++;
               $display("FAIL mon_in_ready t=%0t got=%0b exp=%0b", $time, in_ready, (e_cnt != 3'(DEPTH)));
            end
            if ({wr_en, wr_addr} !== {e_en, e_addr}) begin
               failures++;
               $display("FAIL mon_wr_addr t=%0t got=%0b/%0d exp=%0b/%0d", $time, wr_en, wr_addr, e_en, e_addr);
            end
            if (wr_data !== e_data) begin
               failures++;
               $display("FAIL mon_wr_data t=%0t got=%0h exp=%0h", $time, wr_data, e_data);
            end
            if ({hit1, fwd1} !== {e_h1, e_f1}) begin
               failures++;
               $display("FAIL mon_bypass1 t=%0t a=%0d got=%0b/%0h exp=%0b/%0h", $time, q_a1, hit1, fwd1, e_h1, e_f1);
            end
            if ({hit2, fwd2} !== {e_h2, e_f2}) begin
               failures++;
               $display("FAIL mon_bypass2 t=%0t a=%0d got=%0b/%0h exp=%0b/%0h", $time, q_a2, hit2, fwd2, e_h2, e_f2);
            end
            if (wr_en === 1'b1) wlog.push_back(wr_addr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got=running exp=finished", $time);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_rd = 5'd7; in_data = 64'h55;
      q_a1 = 5'd7; q_a2 = 5'd0;
      #3;
      checks++;
      if ({wr_en, wr_addr, wr_data, count, in_ready, hit1, hit2, fwd1, fwd2} !== {1'b0, 5'd0, 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0}) begin
         failures++;
         $display("FAIL reset_state got=wr_en%0b addr%0d cnt%0d rdy%0b hit%0b%0b exp=0/0/0/1/00", wr_en, wr_addr, count, in_ready, hit1, hit2);
      end
      tick(); tick();
      in_valid = 1'b0;
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_single_write();
      idle(2);
      in_valid = 1'b1; in_rd = 5'd5; in_data = 64'h1234;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 5'd5, 64'h1234, 3'd1}) begin
         failures++;
         $display("FAIL single_present got=%0b/%0d/%0h/%0d exp=1/5/1234/1", wr_en, wr_addr, wr_data, count);
      end
      tick();
      checks++;
      if ({wr_en, count} !== {1'b0, 3'd0}) begin
         failures++;
         $display("FAIL single_drained got=%0b/%0d exp=0/0", wr_en, count);
      end
   endtask

   task automatic test_backpressure();
      idle(2);
      wlog.delete();
      for (int i = 1; i <= 6; i++) begin
         in_valid = 1'b1; in_rd = 5'(i); in_data = 64'(i * 16);
         tick();
      end
      idle(4);
      checks++;
      if (wlog.size() != 6) begin
         failures++;
         $display("FAIL bp_write_count got=%0d exp=6", wlog.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (wlog[i] !== 5'(i + 1)) begin
               failures++;
               $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, wlog[i], i + 1);
            end
         end
      end
   endtask

   task automatic test_x0_drop();
      idle(2);
      wlog.delete();
      in_valid = 1'b1; in_rd = 5'd0; in_data = 64'hFFFF;
      tick();
      checks++;
      if ({count, wr_en} !== {3'd0, 1'b0}) begin
         failures++;
         $display("FAIL x0_not_queued got=%0d/%0b exp=0/0", count, wr_en);
      end
      in_rd = 5'd2; in_data = 64'd7;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 5'd2, 64'd7, 3'd1}) begin
         failures++;
         $display("FAIL x0_second got=%0b/%0d/%0h/%0d exp=1/2/7/1", wr_en, wr_addr, wr_data, count);
      end
      idle(3);
      checks++;
      if ((wlog.size() != 1) || (wlog[0] !== 5'd2)) begin
         failures++;
         $display("FAIL x0_writes got=%0d_writes exp=1_write_to_2", wlog.size());
      end
   endtask

   task automatic test_bypass();
      idle(2);
      q_a1 = 5'd3; q_a2 = 5'd0;
      in_valid = 1'b1; in_rd = 5'd3; in_data = 64'hA;
      tick();
      checks++;
      if ({hit1, fwd1} !== {1'b1, 64'hA}) begin
         failures++;
         $display("FAIL byp_first got=%0b/%0h exp=1/a", hit1, fwd1);
      end
      in_data = 64'hB;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({hit1, fwd1, hit2, fwd2} !== {1'b1, 64'hB, 1'b0, 64'd0}) begin
         failures++;
         $display("FAIL byp_youngest got=%0b/%0h/%0b/%0h exp=1/b/0/0", hit1, fwd1, hit2, fwd2);
      end
      tick();
      checks++;
      if ({hit1, fwd1} !== {1'b0, 64'd0}) begin
         failures++;
         $display("FAIL byp_after_pop got=%0b/%0h exp=0/0", hit1, fwd1);
      end
      q_a1 = 5'd0;
   endtask

   task automatic test_wrap();
      idle(2);
      wlog.delete();
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1; in_rd = 5'(i); in_data = 64'(i * 257);
         q_a2 = 5'(i);
         tick();
         checks++;
         if ({count, wr_addr} !== {3'd1, 5'(i)}) begin
            failures++;
            $display("FAIL wrap_count idx=%0d got=%0d/%0d exp=1/%0d", i, count, wr_addr, i);
         end
      end
      idle(3);
      q_a2 = 5'd0;
      checks++;
      if (wlog.size() != 10) begin
         failures++;
         $display("FAIL wrap_writes got=%0d exp=10", wlog.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (wlog[i] !== 5'(i + 1)) begin
               failures++;
               $display("FAIL wrap_order idx=%0d got=%0d exp=%0d", i, wlog[i], i + 1);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      idle(2);
      q_a1 = 5'd9;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_rd = 5'd9; in_data = 64'(100 + i);
         tick();
      end
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, count, in_ready, hit1, fwd1} !== {1'b0, 3'd0, 1'b1, 1'b0, 64'd0}) begin
         failures++;
         $display("FAIL async_reset got=%0b/%0d/%0b/%0b exp=0/0/1/0", wr_en, count, in_ready, hit1);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      q_a1 = 5'd0;
      test_single_write();
   endtask

   task automatic test_random();
      idle(2);
      for (int i = 0; i < 300; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
         in_data  = {$urandom, $urandom};
         q_a1     = 5'($urandom_range(0, 6));
         q_a2     = 5'($urandom_range(0, 6));
         tick();
      end
      idle(3);
   endtask

   initial begin
      in_valid = 1'b0; in_rd = '0; in_data = '0; q_a1 = '0; q_a2 = '0;
      test_reset();
      test_single_write();
      test_backpressure();
      test_x0_drop();
      test_bypass();
      test_wrap();
      test_async_reset();
      test_random();
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
